// File: rtl/clock_tick_controller_pkg.sv
// ---------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared types and constants for the digital-clock tick controller.
//   mode_t  : operating mode of the sequencer (RUN / SET_HOUR / SET_MIN)
//   SEC_MAX : last valid second value before the carry into minutes
//   MIN_MAX : last valid minute value before the carry into hours
// ---------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/clock_tick_controller_btn_edge_sync.sv
// ---------------------------------------------------------------------------
// btn_edge_sync
// Brings an asynchronous, already-debounced button level into the clk domain
// through a 2-FF synchronizer and emits a one-cycle pulse on its rising edge.
//   clk     : system clock
//   reset_n : asynchronous active-low reset (all flops cleared)
//   i_btn   : raw button level
//   o_rise  : high for one cycle after the synchronized level goes 0 -> 1
// A level sampled at edge n shows up on o_rise during the cycle after edge
// n+1, so a consumer that registers o_rise acts at edge n+2.
// ---------------------------------------------------------------------------
module btn_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Decoded from flops only; a held button yields a single pulse.
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/clock_tick_controller.sv
// ---------------------------------------------------------------------------
// clock_tick_controller
// Sequencer for the digital-clock datapath. Owns the 1 Hz prescaler, the
// seconds -> minutes -> hours carry chain and the RUN / SET_HOUR / SET_MIN
// mode FSM used for setting the time with two buttons.
//
// Parameters
//   TICK_DIV : system clk cycles per second (>= 4)
//   PS_W     : prescaler width, derived from TICK_DIV
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   mode_btn   in   debounced async level; rising edge advances the mode
//   inc_btn    in   debounced async level; rising edge bumps the set field
//   sec_value  in   current seconds count (0..59), used for carry decisions
//   min_value  in   current minutes count (0..59), used for carry decisions
//   sec_tick   out  one-cycle enable to advance seconds
//   sec_clr    out  one-cycle pulse to clear seconds on return to RUN
//   min_tick   out  one-cycle enable to advance minutes
//   hour_tick  out  one-cycle enable to advance hours
//   mode       out  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
//   blink_on   out  display enable for the field being set
//
// Build option
//   CLOCK_CTRL_BLINK_EN : when defined, blink_on toggles every TICK_DIV/4
//   cycles in the set modes; otherwise blink_on is tied high.
// ---------------------------------------------------------------------------
module clock_tick_controller
    import clock_ctrl_pkg::*;
#(
    parameter  int TICK_DIV = 50000000,
    localparam int PS_W     = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [5:0] sec_value,
    input  logic [5:0] min_value,
    output logic       sec_tick,
    output logic       sec_clr,
    output logic       min_tick,
    output logic       hour_tick,
    output logic [1:0] mode,
    output logic       blink_on
);

    localparam logic [PS_W-1:0] PS_TC = PS_W'(TICK_DIV - 1);

    logic w_mode_edge;
    logic w_inc_edge;

    mode_t           r_state;
    logic [PS_W-1:0] r_ps;
    logic            r_sec_tick;
    logic            r_sec_clr;
    logic            r_min_tick;
    logic            r_hour_tick;

    btn_edge_sync u_mode_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (mode_btn),
        .o_rise  (w_mode_edge)
    );

    btn_edge_sync u_inc_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (inc_btn),
        .o_rise  (w_inc_edge)
    );

    // Mode FSM, prescaler and all tick outputs share one registered block so
    // every output is a flop and no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= MODE_RUN;
            r_ps        <= '0;
            r_sec_tick  <= 1'b0;
            r_sec_clr   <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;
        end else begin
            r_sec_tick  <= 1'b0;
            r_sec_clr   <= 1'b0;
            r_min_tick  <= 1'b0;
            r_hour_tick <= 1'b0;

            case (r_state)
                MODE_RUN: begin
                    // Terminal count issues the tick and carries even when a
                    // mode edge arrives in the same cycle.
                    if (r_ps == PS_TC) begin
                        r_ps        <= '0;
                        r_sec_tick  <= 1'b1;
                        r_min_tick  <= (sec_value == SEC_MAX);
                        r_hour_tick <= (sec_value == SEC_MAX) &&
                                       (min_value == MIN_MAX);
                    end else begin
                        r_ps <= r_ps + PS_W'(1);
                    end
                    if (w_mode_edge) begin
                        r_state <= MODE_SET_HOUR;
                        r_ps    <= '0;
                    end
                end

                MODE_SET_HOUR: begin
                    r_ps <= '0;
                    // Mode edge has priority; a coincident inc is dropped.
                    if (w_mode_edge) begin
                        r_state <= MODE_SET_MIN;
                    end else if (w_inc_edge) begin
                        r_hour_tick <= 1'b1;
                    end
                end

                MODE_SET_MIN: begin
                    r_ps <= '0;
                    if (w_mode_edge) begin
                        r_state   <= MODE_RUN;
                        r_sec_clr <= 1'b1;
                    end else if (w_inc_edge) begin
                        // Minute set never carries into hours.
                        r_min_tick <= 1'b1;
                    end
                end

                default: begin
                    r_state <= MODE_RUN;
                    r_ps    <= '0;
                end
            endcase
        end
    end

    assign sec_tick  = r_sec_tick;
    assign sec_clr   = r_sec_clr;
    assign min_tick  = r_min_tick;
    assign hour_tick = r_hour_tick;
    assign mode      = r_state;

`ifdef CLOCK_CTRL_BLINK_EN
    localparam logic [PS_W-1:0] BLINK_TC = PS_W'(TICK_DIV / 4 - 1);

    logic            r_blink;
    logic [PS_W-1:0] r_blink_cnt;
    logic            w_in_set;

    assign w_in_set = (r_state == MODE_SET_HOUR) || (r_state == MODE_SET_MIN);

    // Any mode edge means a fresh mode entry (or return to RUN), so the
    // blink phase restarts lit; an inc edge likewise relights the field.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (!w_in_set || w_mode_edge || w_inc_edge) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == BLINK_TC) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + PS_W'(1);
        end
    end

    assign blink_on = r_blink;
`else
    assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_clock_tick_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_tick_controller
// Directed, table-driven bench for clock_tick_controller with TICK_DIV = 4.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, i.e. just after the edge that registered them.
// ---------------------------------------------------------------------------
module tb_clock_tick_controller;

    logic       clk;
    logic       reset_n;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] sec_value;
    logic [5:0] min_value;
    logic       sec_tick;
    logic       sec_clr;
    logic       min_tick;
    logic       hour_tick;
    logic [1:0] mode;
    logic       blink_on;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_sec, cnt_min, cnt_hour, cnt_clr;

    // exp = {sec_tick, sec_clr, min_tick, hour_tick, mode[1:0]} after the edge
    typedef struct {
        logic       mb;
        logic       ib;
        logic [5:0] sv;
        logic [5:0] mv;
        logic [5:0] exp;
    } vec_t;

    vec_t vq[$];

    clock_tick_controller #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .sec_value (sec_value),
        .min_value (min_value),
        .sec_tick  (sec_tick),
        .sec_clr   (sec_clr),
        .min_tick  (min_tick),
        .hour_tick (hour_tick),
        .mode      (mode),
        .blink_on  (blink_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr_counts();
        cnt_sec = 0; cnt_min = 0; cnt_hour = 0; cnt_clr = 0;
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cnt_sec  += int'(sec_tick);
            cnt_min  += int'(min_tick);
            cnt_hour += int'(hour_tick);
            cnt_clr  += int'(sec_clr);
        end
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step(); step(); step();
        mode_btn = 1'b0;
        step(); step();
    endtask

    task automatic add(input logic mb, input logic ib, input int sv, input int mv,
                       input logic [5:0] exp);
        vec_t v;
        v.mb = mb; v.ib = ib; v.sv = 6'(sv); v.mv = 6'(mv); v.exp = exp;
        vq.push_back(v);
    endtask

    initial begin
        logic prev_b;
        logic exp_b;

        reset_n   = 1'b0;
        mode_btn  = 1'b0;
        inc_btn   = 1'b0;
        sec_value = 6'd0;
        min_value = 6'd0;

        // RUN from reset: ticks on the 4th, 8th, 12th ... edge after release.
        add(0, 0, 10,  0, 6'b0000_00);
        add(0, 0, 10,  0, 6'b0000_00);
        add(0, 0, 10,  0, 6'b0000_00);
        add(0, 0, 10,  0, 6'b1000_00);
        add(0, 0, 10,  0, 6'b0000_00);
        add(0, 0, 10,  0, 6'b0000_00);
        add(0, 0, 10,  0, 6'b0000_00);
        add(0, 0, 59, 10, 6'b1010_00);
        add(0, 0, 59, 59, 6'b0000_00);
        add(0, 0, 59, 59, 6'b0000_00);
        add(0, 0, 59, 59, 6'b0000_00);
        add(0, 0, 59, 59, 6'b1011_00);
        add(0, 0,  0, 59, 6'b0000_00);
        add(0, 0,  0, 59, 6'b0000_00);
        add(0, 0,  0, 59, 6'b0000_00);
        add(0, 0, 58, 59, 6'b1000_00);
        add(0, 0,  0,  0, 6'b0000_00);
        // mode sampled at edge 18 lands at edge 20, same edge as terminal count
        add(1, 0,  0,  0, 6'b0000_00);
        add(1, 0, 59, 59, 6'b0000_00);
        add(1, 0, 59, 59, 6'b1011_01);
        add(0, 0,  0,  0, 6'b0000_01);

        step(); step();
        check("reset_outputs", {2'b0, sec_tick, sec_clr, min_tick, hour_tick, mode},
              8'b0000_0000);
        check("reset_blink", {7'b0, blink_on}, 8'd1);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            mode_btn  = vq[i].mb;
            inc_btn   = vq[i].ib;
            sec_value = vq[i].sv;
            min_value = vq[i].mv;
            step();
            check($sformatf("vec%0d", i),
                  {2'b0, sec_tick, sec_clr, min_tick, hour_tick, mode},
                  {2'b0, vq[i].exp});
        end
        mode_btn = 1'b0;
        sec_value = 6'd10;
        min_value = 6'd0;

        // SET_HOUR: clock paused
        clr_counts();
        run_count(20);
        check("pause_sec_ticks", 8'(cnt_sec), 8'd0);
        check("pause_mode", {6'b0, mode}, 8'd1);

`ifdef CLOCK_CTRL_BLINK_EN
        prev_b = blink_on;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_b = ~prev_b;
            check("blink_toggle", {7'b0, blink_on}, {7'b0, exp_b});
            prev_b = blink_on;
        end
`else
        for (int i = 0; i < 4; i++) begin
            step();
            exp_b = 1'b1;
            check("blink_const", {7'b0, blink_on}, {7'b0, exp_b});
        end
        prev_b = blink_on;
`endif

        // inc pulse latency and single hour_tick
        inc_btn = 1'b1;
        step(); step();
        check("inc_lat_early", {7'b0, hour_tick}, 8'd0);
        step();
        check("inc_hour_tick", {5'b0, sec_tick, min_tick, hour_tick}, 8'b001);
        inc_btn = 1'b0;
        step();
        check("inc_hour_single", {7'b0, hour_tick}, 8'd0);
        step(); step();

        // held inc: exactly one event
        clr_counts();
        inc_btn = 1'b1;
        run_count(10);
        inc_btn = 1'b0;
        run_count(4);
        check("held_hour_count", 8'(cnt_hour), 8'd1);
        check("held_min_count", 8'(cnt_min), 8'd0);

        // mode and inc edges coincide: mode wins, inc dropped
        clr_counts();
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        run_count(3);
        check("simul_mode", {6'b0, mode}, 8'd2);
        run_count(3);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        run_count(3);
        check("simul_no_inc_tick", 8'(cnt_hour + cnt_min), 8'd0);

        // SET_MIN inc with minute at 59: no hour carry
        sec_value = 6'd59;
        min_value = 6'd59;
        inc_btn = 1'b1;
        step(); step(); step();
        check("setmin_tick", {5'b0, sec_tick, min_tick, hour_tick}, 8'b010);
        inc_btn = 1'b0;
        clr_counts();
        run_count(4);
        check("setmin_single", 8'(cnt_min + cnt_hour), 8'd0);

        // back to RUN: sec_clr pulse and prescaler restart
        mode_btn = 1'b1;
        step(); step();
        check("exit_early", {5'b0, mode, sec_clr}, 8'b100);
        step();
        check("exit_run", {5'b0, mode, sec_clr}, 8'b001);
        mode_btn  = 1'b0;
        sec_value = 6'd10;
        min_value = 6'd0;
        step();
        check("clr_single", {6'b0, sec_clr, sec_tick}, 8'd0);
        step(); step();
        check("restart_early", {7'b0, sec_tick}, 8'd0);
        step();
        check("restart_tick", {5'b0, sec_tick, min_tick, hour_tick}, 8'b100);
        check("run_blink", {7'b0, blink_on}, 8'd1);

        // inc in RUN is ignored; seconds keep ticking
        clr_counts();
        inc_btn = 1'b1;
        run_count(3);
        inc_btn = 1'b0;
        run_count(5);
        check("run_inc_ignored", 8'(cnt_hour + cnt_min), 8'd0);
        check("run_sec_count", 8'(cnt_sec), 8'd2);

        // async reset in SET_MIN while a tick is high
        press_mode();
        press_mode();
        check("pre_reset_mode", {6'b0, mode}, 8'd2);
        inc_btn = 1'b1;
        step(); step(); step();
        check("pre_reset_min_tick", {7'b0, min_tick}, 8'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset", {1'b0, blink_on, sec_tick, sec_clr, min_tick, hour_tick, mode},
              8'b0100_0000);
        inc_btn = 1'b0;
        step(); step();
        check("held_reset", {1'b0, blink_on, sec_tick, sec_clr, min_tick, hour_tick, mode},
              8'b0100_0000);
        reset_n = 1'b1;
        clr_counts();
        run_count(4);
        check("post_reset_run", {6'b0, mode}, 8'd0);
        check("post_reset_no_set_tick", 8'(cnt_min + cnt_hour + cnt_clr), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
